// File: rtl/tft_pkg.sv
// Shared types and constants for the ILI9341-class parallel panel streamer.
// Init ROM entries are {flag[1:0], value[7:0]}: 0xx command, 1xx parameter, 2xx delay in ms.
package tft_pkg;

    // state        | meaning
    // S_RESET_LOW  | panel reset held low
    // S_RESET_WAIT | panel reset released, settling
    // S_INIT       | walking the init ROM
    // S_SLEEP_OUT  | issue SLPOUT, then wait for wake-up
    // S_DISP_ON    | issue DISPON
    // S_RAMWR      | issue first RAMWR, enter streaming
    // S_STREAM     | pixels and sync-line handling
    // S_ROT_PARAM  | MADCTL parameter of a rotation update
    // S_SYNC_RAMWR | RAMWR closing a rotation update
    typedef enum logic [3:0] {
        S_RESET_LOW,
        S_RESET_WAIT,
        S_INIT,
        S_SLEEP_OUT,
        S_DISP_ON,
        S_RAMWR,
        S_STREAM,
        S_ROT_PARAM,
        S_SYNC_RAMWR
    } state_t;

    localparam logic [7:0] MADCTL_ROT0   = 8'h60;
    localparam logic [7:0] MADCTL_ROT180 = 8'hA0;
    localparam logic [7:0] CMD_SLPOUT    = 8'h11;
    localparam logic [7:0] CMD_DISPON    = 8'h29;
    localparam logic [7:0] CMD_RAMWR     = 8'h2C;
    localparam logic [7:0] CMD_MADCTL    = 8'h36;

    localparam int ROM_FLAG_RS  = 0;
    localparam int ROM_FLAG_DLY = 1;

    localparam int INIT_ROM_LEN = 174;

    localparam logic [9:0] INIT_ROM [0:86] = '{
        10'h001, 10'h205,
        10'h0EF, 10'h103, 10'h180, 10'h102,
        10'h0CF, 10'h100, 10'h1C1, 10'h130,
        10'h0ED, 10'h164, 10'h103, 10'h112, 10'h181,
        10'h0E8, 10'h185, 10'h100, 10'h178,
        10'h0CB, 10'h139, 10'h12C, 10'h100, 10'h134, 10'h102,
        10'h0F7, 10'h120,
        10'h0EA, 10'h100, 10'h100,
        10'h0C0, 10'h123,
        10'h0C1, 10'h110,
        10'h0C5, 10'h13E, 10'h128,
        10'h0C7, 10'h186,
        10'h036, 10'h160,
        10'h03A, 10'h155,
        10'h0B1, 10'h100, 10'h118,
        10'h0B6, 10'h108, 10'h182, 10'h127,
        10'h0F2, 10'h100,
        10'h026, 10'h101,
        10'h0E0, 10'h10F, 10'h131, 10'h12B, 10'h10C, 10'h10E, 10'h108, 10'h14E,
        10'h1F1, 10'h137, 10'h107, 10'h110, 10'h103, 10'h10E, 10'h109, 10'h100,
        10'h0E1, 10'h100, 10'h10E, 10'h114, 10'h103, 10'h111, 10'h107, 10'h131,
        10'h1C1, 10'h148, 10'h108, 10'h10F, 10'h10C, 10'h131, 10'h136, 10'h10F,
        10'h20A
    };

endpackage

// File: rtl/tft_parallel_streamer_bus_writer.sv
// 8080-style write strobe generator: one transfer per command/parameter,
// one (16-bit bus) or two high-byte-first (8-bit bus) transfers per pixel.
module tft_bus_writer #(
    parameter int BUS_W   = 16,
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_rs,
    input  logic             i_pixel,
    input  logic [15:0]      i_word,
    output logic             o_busy,
    output logic             o_wr,
    output logic             o_rs,
    output logic [BUS_W-1:0] o_data
);

    localparam int CYC   = WR_LOW + WR_HIGH;
    localparam int CNT_W = $clog2(CYC + 1);

    logic             r_active;
    logic             r_second;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_lo;
    logic             r_wr;
    logic             r_rs;
    logic [BUS_W-1:0] r_data;
    logic             w_last;

    assign w_last = r_active && (r_cnt == CNT_W'(CYC - 1));
    // The final high cycle already counts as idle so back-to-back transfers are CYC apart.
    assign o_busy = r_active && !(w_last && !r_second);
    assign o_wr   = r_wr;
    assign o_rs   = r_rs;
    assign o_data = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_second <= 1'b0;
            r_cnt    <= '0;
            r_lo     <= 8'h00;
            r_wr     <= 1'b1;
            r_rs     <= 1'b1;
            r_data   <= '0;
        end else begin
            if (r_active) begin
                if (r_cnt == CNT_W'(WR_LOW - 1)) r_wr <= 1'b1;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cnt <= '0;
                    if (r_second) begin
                        r_second <= 1'b0;
                        r_wr     <= 1'b0;
                        r_data   <= BUS_W'(r_lo);
                    end else begin
                        r_active <= 1'b0;
                    end
                end
            end
            if (i_start && !o_busy) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_wr     <= 1'b0;
                r_rs     <= i_rs;
                r_lo     <= i_word[7:0];
                if (BUS_W == 8) begin
                    r_data   <= i_pixel ? BUS_W'(i_word[15:8]) : BUS_W'(i_word[7:0]);
                    r_second <= i_pixel;
                end else begin
                    r_data   <= BUS_W'(i_word);
                    r_second <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tft_parallel_streamer.sv
// Panel power-up sequencer and pixel streamer for ILI9341-class TFTs on an 8080 bus.
// Owns the sequencing FSM, init ROM walk, delay timer and sync-line rotation updates.
module tft_parallel_streamer
    import tft_pkg::*;
#(
    parameter int BUS_W      = 16,
    parameter int COLOR_BITS = 3,
    parameter int TICKS_MS   = 28000,
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int SYNC_LINE  = 216,
    parameter int WR_LOW     = 1,
    parameter int WR_HIGH    = 2,
    parameter int INIT_LEN   = INIT_ROM_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COLOR_BITS-1:0] r,
    input  logic [COLOR_BITS-1:0] g,
    input  logic [COLOR_BITS-1:0] b,
    input  logic [8:0]            hc,
    input  logic [8:0]            vc,
    input  logic                  rotate180,
    output logic                  ready,
    output logic                  overrun,
    output logic                  screen_rd,
    output logic                  screen_wr,
    output logic                  screen_rs,
    output logic                  screen_reset,
    output logic [BUS_W-1:0]      screen_data
);

    localparam int DLY_W = $clog2(256 * TICKS_MS);
    localparam int IDX_W = $clog2(INIT_LEN + 1);

    state_t           r_state, w_state_nxt;
    logic [DLY_W-1:0] r_delay, w_dly_val;
    logic             w_dly_load;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_overrun, w_ovr_nxt;
    logic             r_rot, w_rot_nxt;
    logic             r_sync_pend, w_sync_nxt;
    logic             r_prst, w_prst_nxt;
    logic [8:0]       r_hc_q, r_vc_q;

    logic             w_change, w_pix_evt, w_sync_evt;
    logic             w_busy, w_go;
    logic             w_start, w_rs, w_pixel;
    logic [15:0]      w_word, w_pix565;
    logic [9:0]       w_rom;
    logic [4:0]       w_r5, w_b5;
    logic [5:0]       w_g6;

    assign w_r5     = 5'(r) << (5 - COLOR_BITS);
    assign w_g6     = 6'(g) << (6 - COLOR_BITS);
    assign w_b5     = 5'(b) << (5 - COLOR_BITS);
    assign w_pix565 = {w_b5, w_g6, w_r5};

    assign w_rom      = INIT_ROM[r_idx[IDX_W-1:1]];
    assign w_change   = (hc != r_hc_q) || (vc != r_vc_q);
    assign w_sync_evt = w_change && (vc == 9'(SYNC_LINE)) && (hc == 9'd0);
    assign w_pix_evt  = w_change && (vc < 9'(V_ACTIVE)) && (hc < 9'(H_ACTIVE))
                        && (vc != 9'(SYNC_LINE));
    assign w_go       = !w_busy && (r_delay == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RESET_LOW;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_pixel     = 1'b0;
        w_word      = 16'h0000;
        w_dly_load  = 1'b0;
        w_dly_val   = '0;
        w_idx_nxt   = r_idx;
        w_ready_nxt = r_ready;
        w_ovr_nxt   = r_overrun;
        w_rot_nxt   = r_rot;
        w_sync_nxt  = r_sync_pend;
        w_prst_nxt  = r_prst;
        unique case (r_state)
            S_RESET_LOW: if (w_go) begin
                w_state_nxt = S_RESET_WAIT;
                w_prst_nxt  = 1'b1;
                w_dly_load  = 1'b1;
                w_dly_val   = DLY_W'(120 * TICKS_MS);
            end
            S_RESET_WAIT: if (w_go) w_state_nxt = S_INIT;
            S_INIT: if (w_go) begin
                if (r_idx == IDX_W'(INIT_LEN)) begin
                    w_state_nxt = S_SLEEP_OUT;
                    w_dly_load  = 1'b1;
                    w_dly_val   = DLY_W'(10 * TICKS_MS);
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(2);
                    if (w_rom[8+ROM_FLAG_DLY]) begin
                        w_dly_load = 1'b1;
                        w_dly_val  = DLY_W'(w_rom[7:0]) * DLY_W'(TICKS_MS);
                    end else begin
                        w_start = 1'b1;
                        w_rs    = w_rom[8+ROM_FLAG_RS];
                        w_word  = {8'h00, w_rom[7:0]};
                    end
                end
            end
            S_SLEEP_OUT: if (w_go) begin
                w_start     = 1'b1;
                w_word      = {8'h00, CMD_SLPOUT};
                w_dly_load  = 1'b1;
                w_dly_val   = DLY_W'(120 * TICKS_MS);
                w_state_nxt = S_DISP_ON;
            end
            S_DISP_ON: if (w_go) begin
                w_start     = 1'b1;
                w_word      = {8'h00, CMD_DISPON};
                w_state_nxt = S_RAMWR;
            end
            S_RAMWR: if (w_go) begin
                w_start     = 1'b1;
                w_word      = {8'h00, CMD_RAMWR};
                w_ready_nxt = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_sync_evt || r_sync_pend) begin
                    if (w_busy) begin
                        w_sync_nxt = 1'b1;
                    end else begin
                        w_sync_nxt = 1'b0;
                        w_start    = 1'b1;
                        if (rotate180 != r_rot) begin
                            w_word      = {8'h00, CMD_MADCTL};
                            w_rot_nxt   = rotate180;
                            w_state_nxt = S_ROT_PARAM;
                        end else begin
                            w_word = {8'h00, CMD_RAMWR};
                        end
                    end
                end else if (w_pix_evt) begin
                    if (w_busy) begin
                        w_ovr_nxt = 1'b1;
                    end else begin
                        w_start = 1'b1;
                        w_rs    = 1'b1;
                        w_pixel = 1'b1;
                        w_word  = w_pix565;
                    end
                end
            end
            S_ROT_PARAM: begin
                if (w_pix_evt) w_ovr_nxt = 1'b1;
                if (!w_busy) begin
                    w_start     = 1'b1;
                    w_rs        = 1'b1;
                    w_word      = {8'h00, r_rot ? MADCTL_ROT180 : MADCTL_ROT0};
                    w_state_nxt = S_SYNC_RAMWR;
                end
            end
            S_SYNC_RAMWR: begin
                if (w_pix_evt) w_ovr_nxt = 1'b1;
                if (!w_busy) begin
                    w_start     = 1'b1;
                    w_word      = {8'h00, CMD_RAMWR};
                    w_state_nxt = S_STREAM;
                end
            end
            default: w_state_nxt = S_RESET_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay     <= DLY_W'(200 * TICKS_MS);
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_rot       <= 1'b0;
            r_sync_pend <= 1'b0;
            r_prst      <= 1'b0;
            r_hc_q      <= 9'd0;
            r_vc_q      <= 9'd0;
        end else begin
            if (w_dly_load)            r_delay <= w_dly_val;
            else if (r_delay != '0)    r_delay <= r_delay - DLY_W'(1);
            r_idx       <= w_idx_nxt;
            r_ready     <= w_ready_nxt;
            r_overrun   <= w_ovr_nxt;
            r_rot       <= w_rot_nxt;
            r_sync_pend <= w_sync_nxt;
            r_prst      <= w_prst_nxt;
            r_hc_q      <= hc;
            r_vc_q      <= vc;
        end
    end

    tft_bus_writer #(
        .BUS_W   (BUS_W),
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_writer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_rs    (w_rs),
        .i_pixel (w_pixel),
        .i_word  (w_word),
        .o_busy  (w_busy),
        .o_wr    (screen_wr),
        .o_rs    (screen_rs),
        .o_data  (screen_data)
    );

    assign ready        = r_ready;
    assign overrun      = r_overrun;
    assign screen_rd    = 1'b1;
    assign screen_reset = r_prst;

endmodule

// File: tb/tb_tft_parallel_streamer.sv
// Directed bench: 16-bit and 8-bit bus instances side by side, WR-edge transfer logs, vector table.
`timescale 1ns/1ps
module tb_tft_parallel_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] r, g, b;
    logic [8:0] hc, vc;
    logic       rot;

    logic        rdy16, ovr16, rd16, wr16, rs16, prst16;
    logic [15:0] d16;
    logic        rdy8, ovr8, rd8, wr8, rs8, prst8;
    logic [7:0]  d8;

    always #5 clk = ~clk;

    tft_parallel_streamer #(.BUS_W(16), .COLOR_BITS(3), .TICKS_MS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b), .hc(hc), .vc(vc), .rotate180(rot),
        .ready(rdy16), .overrun(ovr16), .screen_rd(rd16), .screen_wr(wr16), .screen_rs(rs16),
        .screen_reset(prst16), .screen_data(d16));

    tft_parallel_streamer #(.BUS_W(8), .COLOR_BITS(3), .TICKS_MS(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b), .hc(hc), .vc(vc), .rotate180(rot),
        .ready(rdy8), .overrun(ovr8), .screen_rd(rd8), .screen_wr(wr8), .screen_rs(rs8),
        .screen_reset(prst8), .screen_data(d8));

    typedef struct {
        int          t;
        logic        rs;
        logic [15:0] d;
    } xfer_t;

    typedef struct {
        logic [8:0]  hc;
        logic [8:0]  vc;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [2:0]  b;
        int          n16;
        logic [15:0] d16;
    } vec_t;

    xfer_t q16[$];
    xfer_t q8[$];
    vec_t  tbl[9];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic pwr16 = 1'b1, pwr8 = 1'b1, pprst = 1'b0;
    int lowrun16 = 0, lowrun8 = 0;
    int minlow = 99, maxlow = 0;
    int rlow = 0, rrise = -1, rdy_t = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            pwr16 = 1'b1; pwr8 = 1'b1; lowrun16 = 0; lowrun8 = 0;
        end else begin
            if (pwr16 && !wr16) q16.push_back('{cyc, rs16, d16});
            if (pwr8 && !wr8)   q8.push_back('{cyc, rs8, {8'h00, d8}});
            if (!wr16) lowrun16++;
            else if (lowrun16 > 0) begin
                if (lowrun16 < minlow) minlow = lowrun16;
                if (lowrun16 > maxlow) maxlow = lowrun16;
                lowrun16 = 0;
            end
            if (!wr8) lowrun8++;
            else if (lowrun8 > 0) begin
                if (lowrun8 < minlow) minlow = lowrun8;
                if (lowrun8 > maxlow) maxlow = lowrun8;
                lowrun8 = 0;
            end
            pwr16 = wr16;
            pwr8  = wr8;
            if (!prst16) rlow++;
            if (prst16 && !pprst && rrise < 0) rrise = cyc;
            pprst = prst16;
            if (rdy16 && rdy_t < 0) rdy_t = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        int n0, m0, t, mi;

        tbl[0] = '{9'd5,   9'd10,  3'd7, 3'd0, 3'd7, 1, 16'hE01C};
        tbl[1] = '{9'd6,   9'd10,  3'd0, 3'd7, 3'd0, 1, 16'h0700};
        tbl[2] = '{9'd7,   9'd10,  3'd7, 3'd7, 3'd7, 1, 16'hE71C};
        tbl[3] = '{9'd319, 9'd239, 3'd1, 3'd2, 3'd3, 1, 16'h6204};
        tbl[4] = '{9'd320, 9'd10,  3'd7, 3'd7, 3'd7, 0, 16'h0000};
        tbl[5] = '{9'd5,   9'd240, 3'd7, 3'd7, 3'd7, 0, 16'h0000};
        tbl[6] = '{9'd5,   9'd216, 3'd7, 3'd7, 3'd7, 0, 16'h0000};
        tbl[7] = '{9'd100, 9'd0,   3'd3, 3'd5, 3'd1, 1, 16'h250C};
        tbl[8] = '{9'd100, 9'd0,   3'd7, 3'd7, 3'd7, 0, 16'h0000};

        rst_n = 1'b0; r = 3'd0; g = 3'd0; b = 3'd0; hc = 9'd0; vc = 9'd0; rot = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr", wr16, 1);
        chk("rst_rs", rs16, 1);
        chk("rst_panel_reset", prst16, 0);
        chk("rst_data", d16, 0);
        chk("rst_ready", rdy16, 0);
        chk("rst_overrun", ovr16, 0);
        chk("rst_rd", rd16, 1);
        chk("rst_wr8", wr8, 1);

        rst_n = 1'b1;
        t = 0;
        while (!(rdy16 && rdy8) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_within_budget", rdy16 && rdy8, 1);
        repeat (5) @(negedge clk);

        chk_rng("panel_reset_low_cycles", rlow, 799, 802);
        chk("init_xfers16", q16.size(), 88);
        chk("init_xfers8", q8.size(), 88);
        if (q16.size() >= 88) begin
            chk_rng("first_xfer_gap", q16[0].t - rrise, 480, 484);
            chk("first_xfer_rs", q16[0].rs, 0);
            chk("first_xfer_data", q16[0].d, 16'h0001);
            chk_rng("rom_delay_gap", q16[1].t - q16[0].t, 23, 25);
            chk("after_delay_data", q16[1].d, 16'h00EF);
            mi = -1;
            for (int k = 0; k < 80; k++)
                if (mi < 0 && q16[k].rs == 1'b0 && q16[k].d == 16'h0036) mi = k;
            chk("init_madctl_found", mi >= 0, 1);
            if (mi >= 0) begin
                chk("init_madctl_param_rs", q16[mi+1].rs, 1);
                chk("init_madctl_param", q16[mi+1].d, 16'h0060);
            end
            chk("slpout", {15'd0, q16[85].rs, q16[85].d}, 32'h0011);
            chk("dispon", {15'd0, q16[86].rs, q16[86].d}, 32'h0029);
            chk("ramwr",  {15'd0, q16[87].rs, q16[87].d}, 32'h002C);
            chk_rng("slpout_gap", q16[86].t - q16[85].t, 480, 483);
            chk_rng("ready_after_ramwr", rdy_t - q16[87].t, 0, 1);
        end
        chk("wr_low_min", minlow, 1);
        chk("wr_low_max", maxlow, 1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n0 = q16.size(); m0 = q8.size();
            hc = tbl[i].hc; vc = tbl[i].vc; r = tbl[i].r; g = tbl[i].g; b = tbl[i].b;
            repeat (10) @(negedge clk);
            chk($sformatf("vec%0d_count16", i), q16.size() - n0, tbl[i].n16);
            chk($sformatf("vec%0d_count8", i), q8.size() - m0, 2 * tbl[i].n16);
            if (tbl[i].n16 == 1 && q16.size() > n0) begin
                chk($sformatf("vec%0d_data16", i), q16[n0].d, tbl[i].d16);
                chk($sformatf("vec%0d_rs16", i), q16[n0].rs, 1);
            end
            if (tbl[i].n16 == 1 && q8.size() > m0 + 1) begin
                chk($sformatf("vec%0d_hi8", i), q8[m0].d, {8'h00, tbl[i].d16[15:8]});
                chk($sformatf("vec%0d_lo8", i), q8[m0+1].d, {8'h00, tbl[i].d16[7:0]});
                chk($sformatf("vec%0d_rs8", i), q8[m0+1].rs, 1);
            end
        end
        chk("no_overrun_slow", ovr16 | ovr8, 0);

        // sync arriving while the previous pixel is still on the bus is deferred, not lost
        @(negedge clk);
        n0 = q16.size(); m0 = q8.size();
        hc = 9'd319; vc = 9'd215; r = 3'd1; g = 3'd1; b = 3'd1;
        @(negedge clk);
        hc = 9'd0; vc = 9'd216;
        repeat (15) @(negedge clk);
        chk("defer_count16", q16.size() - n0, 2);
        chk("defer_count8", q8.size() - m0, 3);
        if (q16.size() >= n0 + 2) chk("defer_ramwr16", {15'd0, q16[n0+1].rs, q16[n0+1].d}, 32'h002C);
        if (q8.size() >= m0 + 3) chk("defer_ramwr8", {15'd0, q8[m0+2].rs, q8[m0+2].d}, 32'h002C);
        chk("defer_no_overrun", ovr16 | ovr8, 0);

        @(negedge clk);
        n0 = q16.size();
        hc = 9'd1; vc = 9'd100; rot = 1'b1;
        repeat (10) @(negedge clk);
        chk("rot_midframe_count", q16.size() - n0, 1);
        if (q16.size() > n0) chk("rot_midframe_is_pixel", q16[n0].rs, 1);

        @(negedge clk);
        n0 = q16.size(); m0 = q8.size();
        hc = 9'd0; vc = 9'd216;
        repeat (15) @(negedge clk);
        chk("rot_sync_count16", q16.size() - n0, 3);
        chk("rot_sync_count8", q8.size() - m0, 3);
        if (q16.size() >= n0 + 3) begin
            chk("rot_madctl", {15'd0, q16[n0].rs, q16[n0].d}, 32'h0036);
            chk("rot_param",  {15'd0, q16[n0+1].rs, q16[n0+1].d}, 32'h100A0);
            chk("rot_ramwr",  {15'd0, q16[n0+2].rs, q16[n0+2].d}, 32'h002C);
        end
        if (q8.size() >= m0 + 3) chk("rot_param8", q8[m0+1].d, 16'h00A0);

        vc = 9'd50;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            hc = 9'(i + 1);
        end
        @(negedge clk);
        chk("overrun16_set", ovr16, 1);
        chk("overrun8_set", ovr8, 1);
        repeat (30) @(negedge clk);
        chk("overrun16_sticky", ovr16, 1);

        hc = 9'd200;
        @(posedge clk);
        #1;
        chk("wr_low_before_reset", wr16, 0);
        rst_n = 1'b0;
        #1;
        chk("wr_high_on_reset", wr16, 1);
        chk("overrun_cleared", ovr16, 0);
        chk("panel_reset_on_reset", prst16, 0);
        chk("ready_cleared", rdy16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
